// File: rtl/needle_catcher_pkg.sv
// Shared definitions for the needle catcher: FSM state encoding, default
// pulse-width limits and the accepted-pulse counter width.
package needle_catcher_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_HIGH = 2'd0,
        ST_IDLE      = 2'd1,
        ST_LOW       = 2'd2,
        ST_STUCK     = 2'd3
    } state_e;

    localparam int DEFAULT_MIN_WIDTH = 2;
    localparam int DEFAULT_MAX_WIDTH = 200;
    localparam int COUNT_BITS        = 16;

endpackage

// File: rtl/needle_sync.sv
// Flop-chain synchronizer for an asynchronous single-bit input; the chain
// resets to 0. STAGES must be at least 2.
module needle_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);

    logic [STAGES-1:0] chain_q;

    // NOTE: flops use non-blocking assignments so every stage samples the
    // previous stage's old value and the chain really delays by STAGES edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], async_i};
        end
    end

    assign sync_o = chain_q[STAGES-1];

endmodule

// File: rtl/needle_catcher.sv
// Measures the low width of an asynchronous active-low needle pulse train,
// counts accepted pulses and flags glitches, stuck-low lines and lost results.
module needle_catcher
    import needle_catcher_pkg::*;
#(
    parameter int WIDTH_BITS  = 8,
    parameter int MIN_WIDTH   = DEFAULT_MIN_WIDTH,
    parameter int MAX_WIDTH   = DEFAULT_MAX_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  needle_in,
    input  logic                  width_ack,
    output logic                  width_valid,
    output logic [WIDTH_BITS-1:0] width_out,
    output logic [COUNT_BITS-1:0] needle_count,
    output logic                  glitch,
    output logic                  stuck_low,
    output logic                  overrun
);

    logic needle_s;

    needle_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (reset_n),
        .async_i (needle_in),
        .sync_o  (needle_s)
    );

    state_e                state_q, state_d;
    logic [WIDTH_BITS-1:0] cnt_q, cnt_d;
    logic [WIDTH_BITS-1:0] width_q, width_d;
    logic                  width_valid_q, width_valid_d;
    logic [COUNT_BITS-1:0] needle_count_q, needle_count_d;
    logic                  overrun_q, overrun_d;
    logic                  glitch_q, glitch_d;
    logic                  result_evt;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        result_evt = 1'b0;
        glitch_d   = 1'b0;

        if (!enable) begin
            state_d = ST_WAIT_HIGH;
        end else begin
            case (state_q)
                // A line already low at reset release must not be measured.
                ST_WAIT_HIGH: if (needle_s) state_d = ST_IDLE;
                ST_IDLE: begin
                    if (!needle_s) begin
                        state_d = ST_LOW;
                        cnt_d   = WIDTH_BITS'(1);
                    end
                end
                ST_LOW: begin
                    if (!needle_s) begin
                        cnt_d = cnt_q + WIDTH_BITS'(1);
                        if (cnt_q == WIDTH_BITS'(MAX_WIDTH - 1)) state_d = ST_STUCK;
                    end else begin
                        state_d = ST_IDLE;
                        if (cnt_q < WIDTH_BITS'(MIN_WIDTH)) glitch_d   = 1'b1;
                        else                                result_evt = 1'b1;
                    end
                end
                ST_STUCK: if (needle_s) state_d = ST_IDLE;
                default:  state_d = ST_WAIT_HIGH;
            endcase
        end
    end

    always_comb begin
        width_d        = width_q;
        width_valid_d  = width_valid_q;
        needle_count_d = needle_count_q;
        overrun_d      = overrun_q;

        if (width_ack) width_valid_d = 1'b0;

        if (result_evt) begin
            width_d        = cnt_q;
            width_valid_d  = 1'b1;
            needle_count_d = needle_count_q + COUNT_BITS'(1);
            if (width_valid_q && !width_ack) overrun_d = 1'b1;
        end

        // clear wins over a result completing in the same cycle.
        if (clear) begin
            width_d        = width_q;
            width_valid_d  = 1'b0;
            needle_count_d = '0;
            overrun_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_WAIT_HIGH;
            cnt_q          <= '0;
            width_q        <= '0;
            width_valid_q  <= 1'b0;
            needle_count_q <= '0;
            overrun_q      <= 1'b0;
            glitch_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            width_q        <= width_d;
            width_valid_q  <= width_valid_d;
            needle_count_q <= needle_count_d;
            overrun_q      <= overrun_d;
            glitch_q       <= glitch_d;
        end
    end

    assign width_valid  = width_valid_q;
    assign width_out    = width_q;
    assign needle_count = needle_count_q;
    assign glitch       = glitch_q;
    assign stuck_low    = (state_q == ST_STUCK);
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_needle_catcher.sv
// Testbench for needle_catcher: directed scenarios plus random pulse trains
// checked against a pulse-level model of the measurement rules.
module tb_needle_catcher;

    localparam int WB   = 8;
    localparam int MINW = 2;
    localparam int MAXW = 200;
    localparam int SS   = 2;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b1;
    logic          enable    = 1'b0;
    logic          clear     = 1'b0;
    logic          needle_in = 1'b1;
    logic          width_ack = 1'b0;
    logic          width_valid;
    logic [WB-1:0] width_out;
    logic [15:0]   needle_count;
    logic          glitch;
    logic          stuck_low;
    logic          overrun;

    int n_tests = 0;
    int n_fail  = 0;

    // Event monitors, sampled away from the active edge.
    int   glitch_cycles = 0;
    int   stuck_rises   = 0;
    logic stuck_prev    = 1'b0;

    // Pulse-level reference model.
    bit m_valid   = 1'b0;
    int m_width   = 0;
    int m_count   = 0;
    bit m_overrun = 1'b0;
    int m_glitches = 0;
    int m_stucks   = 0;

    always #5 clk = ~clk;

    needle_catcher #(
        .WIDTH_BITS  (WB),
        .MIN_WIDTH   (MINW),
        .MAX_WIDTH   (MAXW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .clear        (clear),
        .needle_in    (needle_in),
        .width_ack    (width_ack),
        .width_valid  (width_valid),
        .width_out    (width_out),
        .needle_count (needle_count),
        .glitch       (glitch),
        .stuck_low    (stuck_low),
        .overrun      (overrun)
    );

    always @(negedge clk) begin
        if (glitch === 1'b1) glitch_cycles++;
        if (stuck_low === 1'b1 && stuck_prev !== 1'b1) stuck_rises++;
        stuck_prev = stuck_low;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Outcome of one low pulse of the given width, from the measurement rules.
    task automatic model_pulse(input int low);
        if (low < MINW) begin
            m_glitches++;
        end else if (low >= MAXW) begin
            m_stucks++;
        end else begin
            if (m_valid) m_overrun = 1'b1;
            m_valid = 1'b1;
            m_width = low;
            m_count = (m_count + 1) % 65536;
        end
    endtask

    task automatic pulse(input int low, input int high);
        needle_in = 1'b0;
        step(low);
        needle_in = 1'b1;
        step(high);
        model_pulse(low);
    endtask

    task automatic check_model(input string tag);
        step(6);
        check({tag, ":valid"},   32'(width_valid),  32'(m_valid));
        check({tag, ":width"},   32'(width_out),    32'(m_width));
        check({tag, ":count"},   32'(needle_count), 32'(m_count));
        check({tag, ":overrun"}, 32'(overrun),      32'(m_overrun));
        check({tag, ":glitches"}, 32'(glitch_cycles), 32'(m_glitches));
        check({tag, ":stucks"},  32'(stuck_rises),  32'(m_stucks));
        check({tag, ":stuck"},   32'(stuck_low),    32'd0);
    endtask

    task automatic do_ack();
        width_ack = 1'b1;
        step(1);
        width_ack = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        m_valid   = 1'b0;
        m_count   = 0;
        m_overrun = 1'b0;
    endtask

    initial begin
        // Reset with the line idle high.
        enable = 1'b1;
        #2 reset_n = 1'b0;
        step(3);
        check("rst:valid", 32'(width_valid), 32'd0);
        check("rst:width", 32'(width_out), 32'd0);
        check("rst:count", 32'(needle_count), 32'd0);
        check("rst:glitch", 32'(glitch), 32'd0);
        check("rst:stuck", 32'(stuck_low), 32'd0);
        check("rst:overrun", 32'(overrun), 32'd0);
        reset_n = 1'b1;
        step(4);

        // 10-cycle pulse: result appears SYNC_STAGES+1 edges after the rise.
        needle_in = 1'b0;
        step(10);
        needle_in = 1'b1;
        step(2);
        check("p10:early", 32'(width_valid), 32'd0);
        step(1);
        check("p10:valid", 32'(width_valid), 32'd1);
        check("p10:width", 32'(width_out), 32'd10);
        check("p10:count", 32'(needle_count), 32'd1);
        model_pulse(10);
        width_ack = 1'b1;
        step(1);
        width_ack = 1'b0;
        m_valid = 1'b0;
        check("p10:acked", 32'(width_valid), 32'd0);
        check_model("p10");

        // One-cycle pulse is a glitch strobing for exactly one cycle.
        needle_in = 1'b0;
        step(1);
        needle_in = 1'b1;
        step(3);
        check("g1:strobe", 32'(glitch), 32'd1);
        step(1);
        check("g1:strobe_end", 32'(glitch), 32'd0);
        model_pulse(1);
        check_model("g1");

        // Line held low for 250 cycles.
        needle_in = 1'b0;
        step(201);
        check("stk:before", 32'(stuck_low), 32'd0);
        step(1);
        check("stk:rise", 32'(stuck_low), 32'd1);
        step(48);
        check("stk:held", 32'(stuck_low), 32'd1);
        needle_in = 1'b1;
        step(2);
        check("stk:hold_sync", 32'(stuck_low), 32'd1);
        step(1);
        check("stk:drop", 32'(stuck_low), 32'd0);
        model_pulse(250);
        check_model("stk");

        // Two unread results: the second overwrites and overrun sets.
        pulse(7, 4);
        pulse(12, 6);
        check_model("ovr");
        do_clear();
        check_model("ovr_clr");

        // Second result lands in the same cycle as width_ack: no overrun.
        pulse(8, 6);
        needle_in = 1'b0;
        step(9);
        needle_in = 1'b1;
        step(2);
        width_ack = 1'b1;
        step(1);
        width_ack = 1'b0;
        m_valid = 1'b1;
        m_width = 9;
        m_count = (m_count + 1) % 65536;
        check_model("ackcoll");
        do_ack();

        // Disabling mid-pulse discards the pulse.
        needle_in = 1'b0;
        step(5);
        enable = 1'b0;
        step(2);
        needle_in = 1'b1;
        step(3);
        enable = 1'b1;
        check_model("en_pulse");

        // Disabling while stuck drops stuck_low.
        needle_in = 1'b0;
        step(205);
        check("en_stk:stuck", 32'(stuck_low), 32'd1);
        enable = 1'b0;
        step(1);
        check("en_stk:off", 32'(stuck_low), 32'd0);
        needle_in = 1'b1;
        step(2);
        enable = 1'b1;
        m_stucks++;
        check_model("en_stk");

        // Line low across reset release: only the later pulse is reported.
        reset_n = 1'b0;
        needle_in = 1'b0;
        step(2);
        reset_n = 1'b1;
        m_valid = 1'b0;
        m_width = 0;
        m_count = 0;
        m_overrun = 1'b0;
        step(10);
        needle_in = 1'b1;
        step(4);
        pulse(5, 6);
        check_model("rst_low");

        // Counter wrap from 16'hFFFF to 0.
        force dut.needle_count_q = 16'hFFFE;
        step(1);
        release dut.needle_count_q;
        m_count = 65534;
        pulse(3, 6);
        check_model("wrap_ffff");
        pulse(4, 6);
        check_model("wrap_zero");

        // clear in the completion cycle drops the result.
        pulse(6, 6);
        needle_in = 1'b0;
        step(6);
        needle_in = 1'b1;
        step(2);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        m_valid = 1'b0;
        m_count = 0;
        m_overrun = 1'b0;
        check_model("clr_coll");

        // Random pulse trains including glitches and stuck-low boundaries.
        for (int t = 0; t < 30; t++) begin
            int k;
            k = int'($urandom_range(1, 4));
            for (int p = 0; p < k; p++) begin
                int r;
                int low;
                r = int'($urandom_range(0, 9));
                if (r == 0)      low = 1;
                else if (r == 1) low = int'($urandom_range(MAXW - 2, MAXW + 3));
                else             low = int'($urandom_range(MINW, 40));
                pulse(low, int'($urandom_range(1, 3)));
            end
            check_model($sformatf("rnd%0d", t));
            if ($urandom_range(0, 1) == 1) do_ack();
            if ($urandom_range(0, 7) == 0) do_clear();
        end
        check_model("rnd_end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
